trigger_rx_pulse_scheduler: RTL and testbench
=============================================

// Module: trigger_rx_pulse_scheduler
// PURPOSE
//  Sequences the trigger RX output path. It accepts received trigger timestamps
//  (WR TAI + 125 MHz cycles) and adds the programmed coarse delay. Results are
//  queued in time order of arrival, and a fixed-width pulse is fired on the DIO
//  output when WR time reaches each target.
//  Sits between the trigger RX decoder (upstream, valid/ready) and the DIO output
//  buffer, in the clk_ref (125 MHz) timing domain.
// PARAMETERS
//  g_queue_depth     16           pending targets; power of 2, >=2
//  g_pulse_width     8            pulse_o high time in clk_ref cycles, >=1
//  g_cycles_per_sec  125000000    cycle counter modulus
// PORTS
//  clk_ref_i         in   1   125 MHz WR reference clock
//  rst_n_i           in   1   asynchronous, active-low reset
//  enable_i          in   1   block enable (TRX_CR.ENABLE)
//  rst_cnt_i         in   1   1-cycle strobe: clear counters (TRX_CR.RST_CNT)
//  delay_c_i         in   28  coarse delay, cycles; sampled at input accept
//  ts_valid_i        in   1   input timestamp valid
//  ts_ready_o        out  1   scheduler can accept
//  ts_tai_i          in   40  input timestamp, TAI seconds
//  ts_cycles_i       in   28  input timestamp, cycles (< g_cycles_per_sec)
//  tm_time_valid_i   in   1   WR time valid (PPS/lock)
//  tm_tai_i          in   40  current WR TAI seconds
//  tm_cycles_i       in   28  current WR cycles
//  pulse_o           out  1   trigger output pulse
//  queue_count_o     out  5   entries in queue ($clog2(depth)+1)
//  cnt_sched_o       out  32  pulses fired (wraps at 2^32)
//  cnt_miss_o        out  32  targets dropped as late (wraps at 2^32)
// BEHAVIOUR
//  - Reset: pulse_o=0, ts_ready_o=0, queue_count_o=0, counters=0, queue empty,
//    FSM=IDLE. Async assert, synchronous release.
//  - Accept: handshake on ts_valid_i & ts_ready_o.
//    ts_ready_o = enable_i & (count + adder-stage occupancy < g_queue_depth).
//    Registered.
//  - Adder stage (1 cycle): cyc = ts_cycles + min(delay_c, g_cycles_per_sec-1).
//    If cyc >= g_cycles_per_sec: cyc -= g_cycles_per_sec and tai+1.
//    TAI wraps mod 2^40.
//    Result is written to the FIFO the next cycle, so accept -> visible in queue
//    = 2 cycles.
//  - Time compare: {tai,cycles} as 68-bit unsigned.
//  - FSM:
//    IDLE  : queue non-empty -> LOAD.
//    LOAD  : pop head into target register (1 cycle) -> WAIT.
//    WAIT  : tm_time_valid_i=0 -> hold.
//            now==target -> PULSE, with pulse_o=1 at the same edge, so pulse_o is
//            high 1 cycle after tm equals target; cnt_sched+1.
//            now>target -> cnt_miss+1, -> IDLE.
//    PULSE : pulse_o held g_pulse_width cycles total, then pulse_o=0 -> IDLE.
//  - Back-to-back: the next target is evaluated only after PULSE ends and LOAD
//    completes. A target inside that window is counted missed.
//  - Simultaneous push/pop: both take effect; count unchanged.
//  - Full: ts_ready_o low. No input is dropped inside the block.
//  - enable_i=0: next edge flushes the queue and the adder stage, forces
//    FSM=IDLE and pulse_o=0 (aborts any pulse). ts_ready_o=0. Counters are kept.
//  - rst_cnt_i: counters=0 next cycle. Clear wins over a same-cycle increment.
//  - Reset mid-pulse: pulse_o drops asynchronously.
// TESTING
//  1. delay 2000; ts(5,1000); tm counting from (5,0) -> pulse_o rises the cycle
//     after tm=(5,3000), stays high 8 cycles; cnt_sched=1.
//  2. delay 2000; ts(5,124999000) -> target (6,1000); pulse 1 cycle after
//     tm=(6,1000).
//  3. ts(5,10), delay 0, tm already (5,500) -> no pulse; cnt_miss=1;
//     queue_count=0.
//  4. 20 timestamps pushed back-to-back, targets 1 ms apart -> ts_ready_o low
//     once 16 are held; resumes after the first pop; 20 pulses in order;
//     cnt_sched=20.
//  5. enable_i low during PULSE with 5 queued -> pulse_o=0 next cycle;
//     queue_count=0; no further pulses.
//  6. rst_cnt_i on the same cycle as a miss -> cnt_miss=0.
//     tm_time_valid_i low for 1000 cycles in WAIT -> FSM holds; no pulse or miss.

Source files
------------

// File: rtl/trigger_rx_pulse_scheduler.sv
// Trigger RX pulse scheduler: delays received timestamps, queues the targets
// and fires a fixed-width DIO pulse when WR time reaches each one.
module trigger_rx_pulse_scheduler #(
  parameter int g_queue_depth    = 16,
  parameter int g_pulse_width    = 8,
  parameter int g_cycles_per_sec = 125000000
) (
  input  logic        clk_ref_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        rst_cnt_i,
  input  logic [27:0] delay_c_i,
  input  logic        ts_valid_i,
  output logic        ts_ready_o,
  input  logic [39:0] ts_tai_i,
  input  logic [27:0] ts_cycles_i,
  input  logic        tm_time_valid_i,
  input  logic [39:0] tm_tai_i,
  input  logic [27:0] tm_cycles_i,
  output logic        pulse_o,
  output logic [$clog2(g_queue_depth):0] queue_count_o,
  output logic [31:0] cnt_sched_o,
  output logic [31:0] cnt_miss_o
);

  localparam int AW = $clog2(g_queue_depth);
  localparam int CW = AW + 1;
  localparam int PW = (g_pulse_width > 1) ? $clog2(g_pulse_width) : 1;
  localparam logic [28:0] CPS  = 29'(g_cycles_per_sec);
  localparam logic [27:0] DMAX = 28'(g_cycles_per_sec - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, PULSE} state_t;

  state_t state, state_nxt;

  logic          accept;
  logic [27:0]   dly;
  logic [28:0]   sum;
  logic          wrap;
  logic [27:0]   add_cyc;
  logic [39:0]   add_tai;

  logic          stg_vld;
  logic [39:0]   stg_tai;
  logic [27:0]   stg_cyc;

  logic [67:0]   mem [g_queue_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [CW:0]   occ;
  logic          push, pop;
  logic          ready_d;

  logic [67:0]   target, now;
  logic          eq, late;
  logic          hit, miss, pulse;
  logic [PW-1:0] pw_cnt;

  assign accept = ts_valid_i & ts_ready_o;

  // Clamp keeps a single conditional subtract sufficient for the wrap.
  assign dly     = (delay_c_i > DMAX) ? DMAX : delay_c_i;
  assign sum     = {1'b0, ts_cycles_i} + {1'b0, dly};
  assign wrap    = (sum >= CPS);
  assign add_cyc = 28'(wrap ? sum - CPS : sum);
  assign add_tai = ts_tai_i + 40'(wrap);

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stg_vld <= 1'b0;
      stg_tai <= '0;
      stg_cyc <= '0;
    end else if (!enable_i) begin
      stg_vld <= 1'b0;
    end else begin
      stg_vld <= accept;
      if (accept) begin
        stg_tai <= add_tai;
        stg_cyc <= add_cyc;
      end
    end
  end

  assign push      = stg_vld & enable_i;
  assign count_nxt = enable_i ? count + CW'(push) - CW'(pop) : '0;
  assign occ       = {1'b0, count_nxt} + (CW + 1)'(enable_i & accept);
  assign ready_d   = enable_i & (occ < (CW + 1)'(g_queue_depth));

  always_ff @(posedge clk_ref_i) begin
    if (push)
      mem[wr_ptr] <= {stg_tai, stg_cyc};
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ts_ready_o <= 1'b0;
    end else begin
      count      <= count_nxt;
      ts_ready_o <= ready_d;
      if (!enable_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign queue_count_o = count;

  assign now  = {tm_tai_i, tm_cycles_i};
  assign eq   = (now == target);
  assign late = (now > target);

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      target <= '0;
      pw_cnt <= '0;
    end else begin
      state  <= state_nxt;
      if (pop)
        target <= mem[rd_ptr];
      pw_cnt <= (state == PULSE && state_nxt == PULSE) ? pw_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (count != '0) state_nxt = LOAD;
      LOAD:  state_nxt = WAIT;
      WAIT:  if (tm_time_valid_i) begin
               if (eq)        state_nxt = PULSE;
               else if (late) state_nxt = IDLE;
             end
      PULSE: if (pw_cnt == PW'(g_pulse_width - 1)) state_nxt = IDLE;
    endcase
    if (!enable_i)
      state_nxt = IDLE;
  end

  always_comb begin
    pop   = 1'b0;
    pulse = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
    unique case (state)
      IDLE:  ;
      LOAD:  pop = 1'b1;
      WAIT:  begin
               hit  = enable_i & tm_time_valid_i & eq;
               miss = enable_i & tm_time_valid_i & late;
             end
      PULSE: pulse = 1'b1;
    endcase
  end

  assign pulse_o = pulse;

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_sched_o <= '0;
      cnt_miss_o  <= '0;
    end else if (rst_cnt_i) begin
      cnt_sched_o <= '0;
      cnt_miss_o  <= '0;
    end else begin
      if (hit)  cnt_sched_o <= cnt_sched_o + 1'b1;
      if (miss) cnt_miss_o  <= cnt_miss_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_trigger_rx_pulse_scheduler.sv
// Directed bench for trigger_rx_pulse_scheduler.
// WR time is stepped by the stimulus process right after each clock edge.
module tb_trigger_rx_pulse_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        rst_cnt;
  logic [27:0] delay_c;
  logic        ts_valid;
  logic        ts_ready;
  logic [39:0] ts_tai;
  logic [27:0] ts_cycles;
  logic        tm_valid;
  logic [39:0] tm_tai;
  logic [27:0] tm_cycles;
  logic        pulse;
  logic [4:0]  queue_count;
  logic [31:0] cnt_sched;
  logic [31:0] cnt_miss;

  int vectors = 0;
  int miscompares = 0;
  bit tm_run = 1'b0;

  always #4 clk = ~clk;

  trigger_rx_pulse_scheduler dut (
    .clk_ref_i       (clk),
    .rst_n_i         (rst_n),
    .enable_i        (enable),
    .rst_cnt_i       (rst_cnt),
    .delay_c_i       (delay_c),
    .ts_valid_i      (ts_valid),
    .ts_ready_o      (ts_ready),
    .ts_tai_i        (ts_tai),
    .ts_cycles_i     (ts_cycles),
    .tm_time_valid_i (tm_valid),
    .tm_tai_i        (tm_tai),
    .tm_cycles_i     (tm_cycles),
    .pulse_o         (pulse),
    .queue_count_o   (queue_count),
    .cnt_sched_o     (cnt_sched),
    .cnt_miss_o      (cnt_miss)
  );

  task automatic chk(input string tag, input logic [67:0] obs,
                     input logic [67:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tm_run) begin
      if (tm_cycles == 28'd124999999) begin
        tm_cycles = '0;
        tm_tai    = tm_tai + 40'd1;
      end else begin
        tm_cycles = tm_cycles + 28'd1;
      end
    end
  endtask

  task automatic push1(input logic [39:0] tai, input logic [27:0] cyc,
                       input logic [27:0] dly);
    ts_tai    = tai;
    ts_cycles = cyc;
    delay_c   = dly;
    ts_valid  = 1'b1;
    for (int g = 0; g < 20 && !ts_ready; g++) tick();
    tick();
    ts_valid  = 1'b0;
  endtask

  task automatic wait_pulse(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (pulse) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_low();
    for (int i = 0; i < 20 && pulse; i++) tick();
  endtask

  int idx;

  task automatic step();
    bit rdy;
    rdy = ts_ready & ts_valid;
    tick();
    if (rdy) idx++;
    ts_cycles = 28'(idx * 125000);
    ts_valid  = (idx < 20);
  endtask

  initial begin
    bit seen;
    bit anyp;
    int w;

    rst_n = 1'b0; enable = 1'b0; rst_cnt = 1'b0; delay_c = '0;
    ts_valid = 1'b0; ts_tai = '0; ts_cycles = '0;
    tm_valid = 1'b0; tm_tai = '0; tm_cycles = '0;
    repeat (3) tick();
    chk("rst_pulse", 68'(pulse), 68'(0));
    chk("rst_ready", 68'(ts_ready), 68'(0));
    chk("rst_count", 68'(queue_count), 68'(0));
    chk("rst_sched", 68'(cnt_sched), 68'(0));
    chk("rst_miss", 68'(cnt_miss), 68'(0));
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    chk("ready_after_en", 68'(ts_ready), 68'(1));

    // 1: basic delay, width
    tm_valid = 1'b1; tm_tai = 40'd5; tm_cycles = 28'd2900; tm_run = 1'b1;
    push1(40'd5, 28'd1000, 28'd2000);
    wait_pulse(500, seen);
    chk("t1_seen", 68'(seen), 68'(1));
    chk("t1_tm_at_rise", 68'(tm_cycles), 68'(3001));
    w = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse) w++;
      else break;
    end
    chk("t1_width", 68'(w), 68'(8));
    chk("t1_sched", 68'(cnt_sched), 68'(1));

    // 2: cycle wrap into next second
    tm_tai = 40'd6; tm_cycles = 28'd900;
    push1(40'd5, 28'd124999000, 28'd2000);
    wait_pulse(500, seen);
    chk("t2_seen", 68'(seen), 68'(1));
    chk("t2_tai", 68'(tm_tai), 68'(6));
    chk("t2_tm_at_rise", 68'(tm_cycles), 68'(1001));
    wait_low();
    chk("t2_sched", 68'(cnt_sched), 68'(2));
    tm_run = 1'b0;

    // 3: already late
    tm_tai = 40'd5; tm_cycles = 28'd500;
    push1(40'd5, 28'd10, 28'd0);
    anyp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      anyp |= pulse;
    end
    chk("t3_nopulse", 68'(anyp), 68'(0));
    chk("t3_miss", 68'(cnt_miss), 68'(1));
    chk("t3_count", 68'(queue_count), 68'(0));

    // 6a: clear coincides with miss (accept, push, LOAD, WAIT->miss)
    push1(40'd5, 28'd10, 28'd0);
    tick();
    tick();
    tick();
    rst_cnt = 1'b1;
    tick();
    rst_cnt = 1'b0;
    tick();
    chk("t6_miss_cleared", 68'(cnt_miss), 68'(0));
    chk("t6_sched_cleared", 68'(cnt_sched), 68'(0));

    // 6b: time invalid holds WAIT
    tm_valid = 1'b0; tm_tai = 40'd7; tm_cycles = '0;
    push1(40'd6, 28'd0, 28'd0);
    anyp = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      anyp |= pulse;
    end
    chk("t6_hold_nopulse", 68'(anyp), 68'(0));
    chk("t6_hold_nomiss", 68'(cnt_miss), 68'(0));
    chk("t6_hold_count", 68'(queue_count), 68'(0));
    tm_tai = 40'd6; tm_valid = 1'b1;
    wait_pulse(10, seen);
    chk("t6_fire", 68'(seen), 68'(1));
    wait_low();
    chk("t6_sched", 68'(cnt_sched), 68'(1));

    // 5: disable mid-pulse with 5 queued
    tm_tai = 40'd8; tm_cycles = '0;
    for (int k = 0; k < 6; k++)
      push1(40'd8, 28'(1000 + 10 * k), 28'd0);
    repeat (6) tick();
    chk("t5_queued", 68'(queue_count), 68'(5));
    tm_cycles = 28'd1000;
    wait_pulse(10, seen);
    chk("t5_seen", 68'(seen), 68'(1));
    enable = 1'b0;
    tick();
    chk("t5_abort", 68'(pulse), 68'(0));
    chk("t5_flush", 68'(queue_count), 68'(0));
    chk("t5_ready", 68'(ts_ready), 68'(0));
    enable = 1'b1;
    tm_run = 1'b1;
    anyp = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      anyp |= pulse;
    end
    tm_run = 1'b0;
    chk("t5_nomore", 68'(anyp), 68'(0));
    chk("t5_sched", 68'(cnt_sched), 68'(2));
    chk("t5_miss", 68'(cnt_miss), 68'(0));

    // 4: fill to capacity, 20 pulses in order
    rst_cnt = 1'b1;
    tick();
    rst_cnt = 1'b0;
    chk("t4_clr", 68'(cnt_sched), 68'(0));
    tm_tai = 40'd9; tm_cycles = '0;
    idx = 0;
    ts_tai = 40'd9; ts_cycles = '0; delay_c = 28'd100; ts_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!ts_ready) break;
    end
    chk("t4_accepted_full", 68'(idx), 68'(17));
    step();
    step();
    chk("t4_count_full", 68'(queue_count), 68'(16));
    chk("t4_ready_low", 68'(ts_ready), 68'(0));
    for (int k = 0; k < 20; k++) begin
      tm_cycles = 28'(k * 125000 + 100);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (pulse) begin
          seen = 1'b1;
          break;
        end
      end
      chk($sformatf("t4_pulse%0d", k), 68'(seen), 68'(1));
      for (int i = 0; i < 20 && pulse; i++) step();
    end
    ts_valid = 1'b0;
    chk("t4_all_in", 68'(idx), 68'(20));
    chk("t4_sched", 68'(cnt_sched), 68'(20));
    chk("t4_miss", 68'(cnt_miss), 68'(0));
    chk("t4_empty", 68'(queue_count), 68'(0));

    // async reset during a pulse
    push1(40'd9, 28'd2500000, 28'd0);
    tm_cycles = 28'd2500000;
    wait_pulse(10, seen);
    chk("rst_mid_seen", 68'(seen), 68'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pulse", 68'(pulse), 68'(0));
    chk("rst_mid_sched", 68'(cnt_sched), 68'(0));
    chk("rst_mid_ready", 68'(ts_ready), 68'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
